beta_shared_write_fifo: RTL and testbench
=========================================

// Module: beta_shared_write_fifo
// PURPOSE
//  Responder for the Beta "write shared" region (addr[31:16]==3). Beta stores to the DATA word are queued in a FIFO.
//  The laser-projector side drains the FIFO through a valid/ready stream.
//  Beta loads from this region return STATUS; this block's mem_rdata feeds the read mux on read_select==3.
//  Sits between the address decoder (sel_write_shared) and the projector point engine.
// PARAMETERS
//  DEPTH      16  FIFO entries, power of two, >=4
//  AW          4  log2(DEPTH)
//  LOW_WATER   4  irq_low asserted while count <= LOW_WATER
// PORTS
//  clk         in   1   system clock, all logic rising-edge
//  reset       in   1   synchronous, active-high
//  sel         in   1   decoder sel_write_shared
//  mem_addr    in   16  addr[15:0]; word offset = mem_addr[3:2]
//  mem_we      in   1   Beta store strobe, one cycle per store
//  mem_wdata   in   32  Beta store data
//  mem_rdata   out  32  load data, combinational from registered state
//  out_data    out  32  head-of-FIFO word
//  out_valid   out  1   FIFO non-empty
//  out_ready   in   1   consumer accepts out_data this cycle
//  irq_low     out  1   level: count <= LOW_WATER
// BEHAVIOUR
//  Register map (mem_addr[3:2]):
//   0 DATA    W: push mem_wdata; R: 0
//   1 STATUS  R: {16'b0, count[AW:0] zero-ext to 13b, overflow, full, empty}; W: ignored
//   2 CONTROL W: bit0 flush, bit1 clear overflow (self-clearing strobes); R: 0
//   3 -       R: 0; W: ignored
//  Accesses count only when sel=1. mem_we with sel=0 has no effect. mem_rdata=0 when sel=0.
//  Storage: DEPTH x 32 array, wr_ptr/rd_ptr AW bits wrap mod DEPTH, count AW+1 bits 0..DEPTH.
//  push = sel & mem_we & off==0; pop = out_valid & out_ready.
//  Push and pop take effect at the same clock edge. The new count is visible on the next cycle.
//  Full/empty are decided from count before the edge:
//   push & !full: write mem[wr_ptr], wr_ptr+1.
//   push & full: word dropped, overflow<=1 (sticky). Dropped even if pop is in the same cycle.
//   pop & !empty: rd_ptr+1.
//   Simultaneous legal push+pop: count unchanged. Push into an empty FIFO with no pop: out_valid=1 the next cycle.
//  out_data = mem[rd_ptr], valid only while out_valid=1. No bubble between back-to-back pops.
//  full = (count==DEPTH), empty = (count==0), out_valid = !empty.
//  Flush (CONTROL bit0=1): ptrs and count go to 0 at the edge and win over a same-cycle pop. overflow is kept unless bit1 is also set.
//  Clear overflow (bit1): overflow<=0. A same-cycle overflowing push cannot occur (that push targets a different offset).
//  Reset: ptrs=0, count=0, overflow=0 -> out_valid=0, irq_low=1, mem_rdata STATUS=0x1. Array contents are not reset.
//  Reset mid-stream discards all queued words. Any write or pop in the reset cycle is ignored.
//  Latency: store-to-out_valid 1 cycle; pop-to-next-word 1 cycle.
// TESTING
//  1 Reset, then load STATUS -> 0x00000001. out_valid=0, irq_low=1.
//  2 Store 0xA, 0xB, 0xC to DATA, out_ready=0 -> STATUS count=3. out_data=0xA.
//    Then out_ready=1 for 3 cycles -> 0xA, 0xB, 0xC in order, then out_valid=0.
//  3 Fill 16 words -> full=1, irq_low=0. Push 17th (0xDEAD) with concurrent pop -> 0xDEAD dropped, overflow=1, count=15.
//    Write CONTROL=2 -> overflow=0.
//  4 Push 5 words with out_ready held 1 -> one word out per cycle, count never exceeds 1, no word lost. irq_low stays 1.
//  5 Queue 8 words, then CONTROL=1 with out_ready=1 -> next cycle count=0, out_valid=0.
//    Next push appears as out_data after 1 cycle.
//  6 Assert reset with 6 words queued and a push in the same cycle -> after reset count=0 and that push is lost.
//    Wrap test: 40 push/pop pairs preserve order.

Source files
------------

// File: rtl/beta_shared_write_fifo_if.sv
// Bus and stream signals of the Beta write-shared FIFO responder.
// The FIFO is the slave. The Beta bus plus the projector consumer together form the master.
interface beta_shared_write_fifo_if;
   logic        sel;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        irq_low;

   modport master (
      output sel, mem_addr, mem_we, mem_wdata, out_ready,
      input  mem_rdata, out_data, out_valid, irq_low
   );

   modport slave (
      input  sel, mem_addr, mem_we, mem_wdata, out_ready,
      output mem_rdata, out_data, out_valid, irq_low
   );
endinterface

// File: rtl/beta_shared_write_fifo.sv
// Beta "write shared" responder: DATA stores are queued in a FIFO and drained by the projector
// through a valid/ready stream. Loads return STATUS.
module beta_shared_write_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int LOW_WATER = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   beta_shared_write_fifo_if.slave  bus
);

   localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
   localparam logic [AW:0] LOW_WATER_C = (AW+1)'(LOW_WATER);

   typedef enum logic [1:0] {
      OFF_DATA    = 2'd0,
      OFF_STATUS  = 2'd1,
      OFF_CONTROL = 2'd2,
      OFF_UNUSED  = 2'd3
   } reg_off_e;

   logic [31:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          overflow;

   reg_off_e off;
   logic     wr_access;
   logic     push;
   logic     pop;
   logic     flush;
   logic     clr_ovf;
   logic     full;
   logic     empty;
   logic     do_push;
   logic     unused_addr;

   assign off         = reg_off_e'(bus.mem_addr[3:2]);
   assign unused_addr = ^{bus.mem_addr[15:4], bus.mem_addr[1:0]};

   assign wr_access = bus.sel & bus.mem_we;
   assign push      = wr_access & (off == OFF_DATA);
   assign flush     = wr_access & (off == OFF_CONTROL) & bus.mem_wdata[0];
   assign clr_ovf   = wr_access & (off == OFF_CONTROL) & bus.mem_wdata[1];

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign pop     = bus.out_valid & bus.out_ready;
   assign do_push = push & ~full;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         // Flush beats a same-cycle pop; overflow survives unless cleared alongside.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         if (clr_ovf) overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // A full FIFO drops the word even when a pop frees a slot at the same edge.
         if (push && full)  overflow <= 1'b1;
         else if (clr_ovf)  overflow <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset; stale words are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr] <= bus.mem_wdata;
   end

   assign bus.out_data  = mem[rd_ptr];
   assign bus.out_valid = ~empty;
   assign bus.irq_low   = (count <= LOW_WATER_C);

   // NOTE: give every always_comb output a default first so no path infers a latch.
   always_comb begin
      bus.mem_rdata = '0;
      if (bus.sel && off == OFF_STATUS)
         bus.mem_rdata = {16'h0, 13'(count), overflow, full, empty};
   end

endmodule

// File: tb/tb_beta_shared_write_fifo.sv
// Self-checking bench for beta_shared_write_fifo: a queue scoreboard tracks every accepted word
// and the expected overflow flag, and each scenario task checks STATUS and the stream.
module tb_beta_shared_write_fifo;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   logic [31:0] exp_q [$];
   logic        m_ovf = 1'b0;

   always #5 clk = ~clk;

   beta_shared_write_fifo_if bus_if ();

   beta_shared_write_fifo #(.DEPTH(16), .AW(4), .LOW_WATER(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   function automatic logic [31:0] exp_status();
      int n = exp_q.size();
      return {16'h0, 13'(n), m_ovf, (n == 16), (n == 0)};
   endfunction

   // One clock: checks pre-edge outputs against the model, updates the model, then advances.
   task automatic tick();
      logic wr;
      logic [1:0] off;
      logic was_full;
      @(negedge clk);
      n_vec++;
      if (bus_if.out_valid !== (exp_q.size() != 0)) begin
         n_err++;
         $display("FAIL out_valid: got %b expected %b", bus_if.out_valid, exp_q.size() != 0);
      end
      n_vec++;
      if (bus_if.irq_low !== (exp_q.size() <= 4)) begin
         n_err++;
         $display("FAIL irq_low: got %b expected %b (count %0d)", bus_if.irq_low, exp_q.size() <= 4, exp_q.size());
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         if (bus_if.out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL out_data: got %h expected %h", bus_if.out_data, exp_q[0]);
         end
      end
      wr  = bus_if.sel & bus_if.mem_we;
      off = bus_if.mem_addr[3:2];
      if (reset) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else if (wr && off == 2'd2 && bus_if.mem_wdata[0]) begin
         exp_q.delete();
         if (bus_if.mem_wdata[1]) m_ovf = 1'b0;
      end else begin
         was_full = (exp_q.size() == 16);
         if (bus_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (wr && off == 2'd0) begin
            if (was_full) m_ovf = 1'b1;
            else          exp_q.push_back(bus_if.mem_wdata);
         end
         if (wr && off == 2'd2 && bus_if.mem_wdata[1]) m_ovf = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus_if.sel       = 1'b0;
      bus_if.mem_we    = 1'b0;
      bus_if.mem_addr  = 16'h0;
      bus_if.mem_wdata = 32'h0;
   endtask

   task automatic store(input logic sel_v, input logic [1:0] off, input logic [31:0] data);
      bus_if.sel       = sel_v;
      bus_if.mem_we    = 1'b1;
      bus_if.mem_addr  = {12'h0, off, 2'b00};
      bus_if.mem_wdata = data;
      tick();
      set_idle();
   endtask

   task automatic check_status(input string name, input logic [31:0] expected);
      bus_if.sel      = 1'b1;
      bus_if.mem_we   = 1'b0;
      bus_if.mem_addr = 16'h0004;
      #1;
      n_vec++;
      if (bus_if.mem_rdata !== expected) begin
         n_err++;
         $display("FAIL %s: STATUS got %h expected %h", name, bus_if.mem_rdata, expected);
      end
      set_idle();
   endtask

   task automatic drain(input int cycles);
      bus_if.out_ready = 1'b1;
      repeat (cycles) tick();
      bus_if.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.out_ready = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_status("reset_status", 32'h0000_0001);
      n_vec++;
      if (bus_if.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
      end
      n_vec++;
      if (bus_if.irq_low !== 1'b1) begin
         n_err++;
         $display("FAIL reset_irq_low: got %b expected 1", bus_if.irq_low);
      end
   endtask

   task automatic test_sel_gating();
      store(1'b0, 2'd0, 32'h1111_1111);
      store(1'b1, 2'd3, 32'h2222_2222);
      store(1'b1, 2'd1, 32'h3333_3333);
      check_status("sel_gating_status", 32'h0000_0001);
      bus_if.sel = 1'b0;
      bus_if.mem_addr = 16'h0004;
      #1;
      n_vec++;
      if (bus_if.mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rdata_unselected: got %h expected 00000000", bus_if.mem_rdata);
      end
      bus_if.sel = 1'b1;
      bus_if.mem_addr = 16'h0000;
      #1;
      n_vec++;
      if (bus_if.mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rdata_data_offset: got %h expected 00000000", bus_if.mem_rdata);
      end
      set_idle();
   endtask

   task automatic test_order();
      store(1'b1, 2'd0, 32'hA);
      store(1'b1, 2'd0, 32'hB);
      store(1'b1, 2'd0, 32'hC);
      check_status("three_queued", 32'h0000_0018);
      n_vec++;
      if (bus_if.out_data !== 32'hA) begin
         n_err++;
         $display("FAIL head_word: got %h expected 0000000a", bus_if.out_data);
      end
      drain(3);
      n_vec++;
      if (bus_if.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drained_valid: got %b expected 0", bus_if.out_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) store(1'b1, 2'd0, 32'h100 + 32'(i));
      check_status("full_status", 32'h0000_0082);
      n_vec++;
      if (bus_if.irq_low !== 1'b0) begin
         n_err++;
         $display("FAIL full_irq_low: got %b expected 0", bus_if.irq_low);
      end
      bus_if.out_ready = 1'b1;
      store(1'b1, 2'd0, 32'hDEAD);
      bus_if.out_ready = 1'b0;
      check_status("overflow_status", 32'h0000_007C);
      store(1'b1, 2'd2, 32'h2);
      check_status("ovf_cleared", 32'h0000_0078);
      drain(15);
      check_status("after_overflow_drain", exp_status());
   endtask

   task automatic test_back_to_back();
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         store(1'b1, 2'd0, 32'h5000 + 32'(i));
         check_status("stream_count", 32'h0000_0008);
      end
      tick();
      bus_if.out_ready = 1'b0;
      check_status("stream_empty", 32'h0000_0001);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 8; i++) store(1'b1, 2'd0, 32'h800 + 32'(i));
      store(1'b1, 2'd1, 32'hFFFF_FFFF);
      check_status("eight_queued", 32'h0000_0040);
      bus_if.out_ready = 1'b1;
      store(1'b1, 2'd2, 32'h1);
      bus_if.out_ready = 1'b0;
      check_status("flushed", 32'h0000_0001);
      store(1'b1, 2'd0, 32'h55);
      n_vec++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 32'h55) begin
         n_err++;
         $display("FAIL post_flush_push: got valid %b data %h expected valid 1 data 00000055",
                  bus_if.out_valid, bus_if.out_data);
      end
      drain(1);
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 6; i++) store(1'b1, 2'd0, 32'h600 + 32'(i));
      reset = 1'b1;
      store(1'b1, 2'd0, 32'hBAD0);
      reset = 1'b0;
      check_status("reset_midstream", 32'h0000_0001);
      tick();
   endtask

   task automatic test_wrap();
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 40; i++) store(1'b1, 2'd0, $urandom);
      tick();
      bus_if.out_ready = 1'b0;
      check_status("wrap_empty", 32'h0000_0001);
   endtask

   initial begin
      test_reset();
      test_sel_gating();
      test_order();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
